// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and constants for the memory port arbiter
package mem_port_arbiter_pkg;
   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } funct3ITypeLOAD_e;
   typedef enum logic [1:0] {IDLE, INST, DATA} memArbState_e;
   typedef enum logic {OWN_INST, OWN_DATA} memOwner_e;
   localparam logic [1:0] SIZE_BYTE = 2'(LB);
   localparam logic [1:0] SIZE_HALF = 2'(LH);
   localparam logic [1:0] SIZE_WORD = 2'(LW);
   localparam int MEM_BE_W = 4;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: access size and address to byte enables, replicated write lanes and misalign flag
module mem_lane_align
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0]          size,
   input  logic [1:0]          addr_lo,
   input  logic [31:0]         wr_data,
   output logic [MEM_BE_W-1:0] be,
   output logic [31:0]         wdata,
   output logic                misaligned
);
   always_comb begin
      be = size == SIZE_BYTE ? MEM_BE_W'(1) << addr_lo :
           size == SIZE_HALF ? MEM_BE_W'(3) << addr_lo : '1;
      wdata = size == SIZE_BYTE ? {4{wr_data[7:0]}} :
              size == SIZE_HALF ? {2{wr_data[15:0]}} : wr_data;
      misaligned = (size == SIZE_HALF && addr_lo[0]) || (size[1] && addr_lo != 2'b00);
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-outstanding memory port between instruction fetch and data access
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT    = 64,
   parameter int DATA_BURST = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clk_en,
   input  logic                inst_rd_en,
   input  logic [31:0]         inst_addr,
   output logic                inst_ready,
   output logic [31:0]         inst_data,
   output logic                inst_err,
   input  logic                data_rd_en,
   input  logic                data_wr_en,
   input  logic [31:0]         data_addr,
   input  logic [31:0]         data_wr,
   input  logic [1:0]          data_rd_wr_ctrl,
   output logic                data_ready,
   output logic [31:0]         data_rd,
   output logic                data_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [31:0]         mem_addr,
   output logic [MEM_BE_W-1:0] mem_be,
   output logic [31:0]         mem_wdata,
   input  logic                mem_ack,
   input  logic [31:0]         mem_rdata
);
   localparam int WAIT_W  = $clog2(TIMEOUT + 1);
   localparam int BURST_W = $clog2(DATA_BURST + 1);

   memArbState_e        state_q, state_d;
   memOwner_e           owner;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [31:0]         mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [MEM_BE_W-1:0] mem_be_q, mem_be_d;
   logic                inst_ready_q, inst_ready_d, inst_err_q, inst_err_d;
   logic                data_ready_q, data_ready_d, data_err_q, data_err_d;
   logic [31:0]         inst_data_q, inst_data_d, data_rd_q, data_rd_d;
   logic [MEM_BE_W-1:0] lane_be;
   logic [31:0]         lane_wdata;
   logic                misaligned, data_req, inst_elig, data_elig;
   logic                grant_inst, grant_data, entering, timeout, done;
   logic                unused_inst_lo;

   assign unused_inst_lo = ^inst_addr[1:0];

   mem_lane_align u_align (
      .size       (data_rd_wr_ctrl),
      .addr_lo    (data_addr[1:0]),
      .wr_data    (data_wr),
      .be         (lane_be),
      .wdata      (lane_wdata),
      .misaligned (misaligned)
   );

   always_comb begin
      data_req = data_rd_en | data_wr_en;
      inst_elig = inst_rd_en & ~inst_ready_q;
      data_elig = data_req & ~data_ready_q;
      // a raw data request blocks instruction grants until the burst quota is spent
      grant_inst = state_q == IDLE && inst_elig && (!data_req || burst_cnt_q == BURST_W'(DATA_BURST));
      grant_data = state_q == IDLE && data_elig && !grant_inst;
      entering = grant_inst || (grant_data && !misaligned);
      timeout = wait_cnt_q == WAIT_W'(TIMEOUT - 1);
      owner = state_q == DATA ? OWN_DATA : OWN_INST;
      done = state_q != IDLE && (mem_ack || timeout);
      state_d = done ? IDLE : grant_inst ? INST : entering ? DATA : state_q;
      wait_cnt_d = (state_q == IDLE || done) ? '0 : wait_cnt_q + WAIT_W'(1);
      burst_cnt_d = (!inst_rd_en || grant_inst) ? '0 :
                    (grant_data && burst_cnt_q != BURST_W'(DATA_BURST)) ? burst_cnt_q + BURST_W'(1) : burst_cnt_q;
      mem_req_d = done ? 1'b0 : entering ? 1'b1 : mem_req_q;
      mem_we_d = done ? 1'b0 : entering ? grant_data & data_wr_en : mem_we_q;
      mem_addr_d = done ? '0 : entering ? {(grant_inst ? inst_addr[31:2] : data_addr[31:2]), 2'b00} : mem_addr_q;
      mem_be_d = done ? '0 : entering ? (grant_inst ? '1 : lane_be) : mem_be_q;
      mem_wdata_d = done ? '0 : entering ? (grant_inst ? '0 : lane_wdata) : mem_wdata_q;
      inst_ready_d = done && owner == OWN_INST;
      inst_err_d = inst_ready_d && !mem_ack;
      inst_data_d = (inst_ready_d && mem_ack) ? mem_rdata : '0;
      data_ready_d = (done && owner == OWN_DATA) || (grant_data && misaligned);
      data_err_d = (done && owner == OWN_DATA && !mem_ack) || (grant_data && misaligned);
      data_rd_d = (done && owner == OWN_DATA && mem_ack && !mem_we_q) ? mem_rdata : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wait_cnt_q   <= '0;
         burst_cnt_q  <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_be_q     <= '0;
         mem_wdata_q  <= '0;
         inst_ready_q <= 1'b0;
         inst_err_q   <= 1'b0;
         inst_data_q  <= '0;
         data_ready_q <= 1'b0;
         data_err_q   <= 1'b0;
         data_rd_q    <= '0;
      end else if (clk_en) begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         burst_cnt_q  <= burst_cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         inst_ready_q <= inst_ready_d;
         inst_err_q   <= inst_err_d;
         inst_data_q  <= inst_data_d;
         data_ready_q <= data_ready_d;
         data_err_q   <= data_err_d;
         data_rd_q    <= data_rd_d;
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;
   assign inst_ready = inst_ready_q;
   assign inst_err   = inst_err_q;
   assign inst_data  = inst_data_q;
   assign data_ready = data_ready_q;
   assign data_err   = data_err_q;
   assign data_rd    = data_rd_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences for burst, timeout, clock enable and reset
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst, clk_en;
   logic        inst_rd_en, inst_ready, inst_err;
   logic [31:0] inst_addr, inst_data;
   logic        data_rd_en, data_wr_en, data_ready, data_err;
   logic [31:0] data_addr, data_wr, data_rd;
   logic [1:0]  data_rd_wr_ctrl;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   mem_port_arbiter #(.TIMEOUT(8), .DATA_BURST(4)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .inst_rd_en(inst_rd_en), .inst_addr(inst_addr), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_err(inst_err),
      .data_rd_en(data_rd_en), .data_wr_en(data_wr_en), .data_addr(data_addr),
      .data_wr(data_wr), .data_rd_wr_ctrl(data_rd_wr_ctrl), .data_ready(data_ready),
      .data_rd(data_rd), .data_err(data_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      logic [1:0]  size;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wr;
      logic [31:0] rdata;
      logic        err;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] maddr;
   } vec_t;

   vec_t vecs[12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int i);
      data_rd_en = ~v.we;
      data_wr_en = v.we;
      data_addr = v.addr;
      data_wr = v.wr;
      data_rd_wr_ctrl = v.size;
      step();
      if (v.err) begin
         chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'd0);
         chk($sformatf("v%0d data_ready", i), 32'(data_ready), 32'd1);
         chk($sformatf("v%0d data_err", i), 32'(data_err), 32'd1);
         chk($sformatf("v%0d data_rd", i), data_rd, 32'd0);
         data_rd_en = 1'b0;
         data_wr_en = 1'b0;
         step();
      end else begin
         chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'd1);
         chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(v.we));
         chk($sformatf("v%0d mem_addr", i), mem_addr, v.maddr);
         chk($sformatf("v%0d mem_be", i), 32'(mem_be), 32'(v.be));
         chk($sformatf("v%0d mem_wdata", i), mem_wdata, v.wdata);
         chk($sformatf("v%0d early ready", i), 32'(data_ready), 32'd0);
         mem_ack = 1'b1;
         mem_rdata = v.rdata;
         step();
         mem_ack = 1'b0;
         mem_rdata = '0;
         chk($sformatf("v%0d data_ready", i), 32'(data_ready), 32'd1);
         chk($sformatf("v%0d data_err", i), 32'(data_err), 32'd0);
         chk($sformatf("v%0d data_rd", i), data_rd, v.we ? 32'd0 : v.rdata);
         chk($sformatf("v%0d req drop", i), 32'(mem_req), 32'd0);
         data_rd_en = 1'b0;
         data_wr_en = 1'b0;
         step();
      end
      chk($sformatf("v%0d ready width", i), 32'(data_ready), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] seq[8];
      string exp_s;
      int ng, cnt;
      logic prev;
      vecs[0]  = '{SIZE_BYTE, 1'b1, 32'h0000_0203, 32'h0000_00A5, 32'h0,         1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0000_0200};
      vecs[1]  = '{SIZE_HALF, 1'b1, 32'h0000_0302, 32'h0000_BEEF, 32'h0,         1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0300};
      vecs[2]  = '{SIZE_WORD, 1'b1, 32'h0000_0400, 32'h1234_5678, 32'h0,         1'b0, 4'b1111, 32'h1234_5678, 32'h0000_0400};
      vecs[3]  = '{SIZE_BYTE, 1'b1, 32'h0000_0000, 32'hFFFF_FF77, 32'h0,         1'b0, 4'b0001, 32'h7777_7777, 32'h0000_0000};
      vecs[4]  = '{SIZE_HALF, 1'b1, 32'h0000_0800, 32'hAAAA_1234, 32'h0,         1'b0, 4'b0011, 32'h1234_1234, 32'h0000_0800};
      vecs[5]  = '{SIZE_BYTE, 1'b0, 32'h0000_0501, 32'h0,         32'h1122_3344, 1'b0, 4'b0010, 32'h0,         32'h0000_0500};
      vecs[6]  = '{SIZE_HALF, 1'b0, 32'h0000_0602, 32'h0,         32'hCAFE_F00D, 1'b0, 4'b1100, 32'h0,         32'h0000_0600};
      vecs[7]  = '{2'b11,     1'b0, 32'h0000_0700, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0,         32'h0000_0700};
      vecs[8]  = '{SIZE_WORD, 1'b0, 32'h0000_0102, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
      vecs[9]  = '{SIZE_HALF, 1'b0, 32'h0000_0105, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
      vecs[10] = '{SIZE_WORD, 1'b1, 32'h0000_0901, 32'h5555_5555, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
      vecs[11] = '{SIZE_WORD, 1'b0, 32'h0000_0A04, 32'h0,         32'h0F0F_0F0F, 1'b0, 4'b1111, 32'h0,         32'h0000_0A04};

      rst = 1'b1; clk_en = 1'b1;
      inst_rd_en = 1'b0; inst_addr = '0;
      data_rd_en = 1'b0; data_wr_en = 1'b0; data_addr = '0; data_wr = '0; data_rd_wr_ctrl = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      step();
      step();
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst mem_we", 32'(mem_we), 32'd0);
      chk("rst mem_addr", mem_addr, 32'd0);
      chk("rst mem_be", 32'(mem_be), 32'd0);
      chk("rst mem_wdata", mem_wdata, 32'd0);
      chk("rst inst_ready", 32'(inst_ready), 32'd0);
      chk("rst inst_err", 32'(inst_err), 32'd0);
      chk("rst inst_data", inst_data, 32'd0);
      chk("rst data_ready", 32'(data_ready), 32'd0);
      chk("rst data_err", 32'(data_err), 32'd0);
      chk("rst data_rd", data_rd, 32'd0);
      chk("rst state", 32'(dut.state_q), 32'd0);
      rst = 1'b0;
      step();

      // instruction read, ack one cycle after mem_req
      inst_addr = 32'h0000_0100;
      inst_rd_en = 1'b1;
      step();
      chk("ifetch mem_req", 32'(mem_req), 32'd1);
      chk("ifetch mem_addr", mem_addr, 32'h100);
      chk("ifetch mem_be", 32'(mem_be), 32'hF);
      chk("ifetch mem_we", 32'(mem_we), 32'd0);
      step();
      chk("ifetch no early ready", 32'(inst_ready), 32'd0);
      mem_ack = 1'b1;
      mem_rdata = 32'h0000_0013;
      step();
      mem_ack = 1'b0;
      mem_rdata = '0;
      chk("ifetch inst_ready", 32'(inst_ready), 32'd1);
      chk("ifetch inst_data", inst_data, 32'h13);
      chk("ifetch inst_err", 32'(inst_err), 32'd0);
      inst_rd_en = 1'b0;
      step();
      chk("ifetch ready width", 32'(inst_ready), 32'd0);

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // both requests held: four data grants then the instruction
      inst_addr = 32'h0000_1000;
      data_addr = 32'h0000_2000;
      data_rd_wr_ctrl = SIZE_WORD;
      inst_rd_en = 1'b1;
      data_rd_en = 1'b1;
      exp_s = "DDDDID";
      ng = 0;
      prev = 1'b0;
      for (int c = 0; c < 60; c++) begin
         step();
         mem_ack = 1'b0;
         if (inst_ready) inst_rd_en = 1'b0;
         if (data_ready && ng >= 6) data_rd_en = 1'b0;
         if (mem_req && !prev) begin
            if (ng < 8) seq[ng] = (mem_addr == 32'h0000_1000) ? 8'h49 : 8'h44;
            ng++;
            mem_ack = 1'b1;
         end
         prev = mem_req;
      end
      chk("burst grant count", 32'(ng), 32'd6);
      for (int i = 0; i < 6; i++) chk($sformatf("burst grant %0d", i), 32'(seq[i]), 32'(exp_s[i]));
      chk("burst_cnt cleared", 32'(dut.burst_cnt_q), 32'd0);

      // timeout with a late ack afterwards
      inst_addr = 32'h0000_0300;
      inst_rd_en = 1'b1;
      step();
      chk("to mem_req", 32'(mem_req), 32'd1);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (mem_req && cnt < 20);
      chk("to cycles", 32'(cnt), 32'd8);
      chk("to inst_ready", 32'(inst_ready), 32'd1);
      chk("to inst_err", 32'(inst_err), 32'd1);
      chk("to inst_data", inst_data, 32'd0);
      inst_rd_en = 1'b0;
      step();
      chk("to ready width", 32'(inst_ready), 32'd0);
      step();
      mem_ack = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      step();
      mem_ack = 1'b0;
      mem_rdata = '0;
      chk("late ack inst_ready", 32'(inst_ready), 32'd0);
      chk("late ack data_ready", 32'(data_ready), 32'd0);
      chk("late ack mem_req", 32'(mem_req), 32'd0);

      // clock-enable freeze, then reset mid-access
      data_addr = 32'h0000_0A00;
      data_rd_wr_ctrl = SIZE_WORD;
      data_rd_en = 1'b1;
      step();
      step();
      step();
      chk("ce wait before", 32'(dut.wait_cnt_q), 32'd2);
      clk_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("ce frozen wait %0d", i), 32'(dut.wait_cnt_q), 32'd2);
         chk($sformatf("ce frozen req %0d", i), 32'(mem_req), 32'd1);
         chk($sformatf("ce frozen addr %0d", i), mem_addr, 32'h0A00);
      end
      clk_en = 1'b1;
      step();
      chk("ce resumed wait", 32'(dut.wait_cnt_q), 32'd3);
      rst = 1'b1;
      step();
      chk("mid rst mem_req", 32'(mem_req), 32'd0);
      chk("mid rst mem_addr", mem_addr, 32'd0);
      chk("mid rst mem_be", 32'(mem_be), 32'd0);
      chk("mid rst data_ready", 32'(data_ready), 32'd0);
      chk("mid rst state", 32'(dut.state_q), 32'd0);
      chk("mid rst wait", 32'(dut.wait_cnt_q), 32'd0);
      rst = 1'b0;
      data_rd_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("post rst no ready %0d", i), 32'(data_ready), 32'd0);
         chk($sformatf("post rst no req %0d", i), 32'(mem_req), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single 32-bit, single-outstanding memory port between the core's instruction-fetch port and its data-access port.
- Byte enables and write-lane alignment are generated from the access size and address.
- Misaligned data accesses and memory timeouts are reported as errors.
- Sits between the `riscv_small` top level and a unified SRAM or bus bridge; the core's `inst_*`/`data_*` ports connect directly.

## Interface
Parameters:
- `TIMEOUT`, 64: cycles without `mem_ack` before a granted access is aborted; must be ≥ 1.
- `DATA_BURST`, 4: maximum consecutive data grants while an instruction request is pending.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `clk_en` in 1: low freezes all state, counters and registered outputs.
- `inst_rd_en` in 1: instruction read request, held until `inst_ready`.
- `inst_addr` in 32: instruction address.
- `inst_ready` out 1: one-cycle completion pulse.
- `inst_data` out 32: read data, valid with `inst_ready`.
- `inst_err` out 1: timeout error, valid with `inst_ready`.
- `data_rd_en` in 1: load request, held until `data_ready`.
- `data_wr_en` in 1: store request, held until `data_ready`; mutually exclusive with `data_rd_en`.
- `data_addr` in 32: byte address.
- `data_wr` in 32: store data, right-aligned.
- `data_rd_wr_ctrl` in 2: access size; 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `data_ready` out 1: one-cycle completion pulse.
- `data_rd` out 32: raw word from memory, not shifted; load extension stays in `memory_access`.
- `data_err` out 1: misalign or timeout error, valid with `data_ready`.
- `mem_req` out 1: memory request, held until `mem_ack` or timeout.
- `mem_we` out 1: write.
- `mem_addr` out 32: word-aligned address; bits [1:0] = 0.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-aligned write data.
- `mem_ack` in 1: one-cycle completion from memory.
- `mem_rdata` in 32: read data, valid with `mem_ack`.

## Operation
- States: IDLE, INST, DATA.
  - All `mem_*` outputs are registered and change only on state entry or exit.
- Arbitration happens in IDLE only. A request is eligible only if its `*_ready` is not asserted this cycle, so a completing request is never re-granted.
  - Data has priority.
  - `burst_cnt` counts consecutive data grants while `inst_rd_en` is pending. When it reaches `DATA_BURST`, the instruction request wins the next arbitration.
  - `burst_cnt` clears on any instruction grant or when `inst_rd_en` is low.
- IDLE → DATA on a data grant with an aligned address.
- IDLE stays IDLE on a misaligned data grant (half with `addr[0]`=1, word with `addr[1:0]`≠0):
  - no `mem_req` is issued;
  - `data_ready` and `data_err` pulse on the next cycle;
  - `data_rd` = 0.
- IDLE → INST on an instruction grant.
- INST/DATA → IDLE on `mem_ack`:
  - next cycle, the owner's `*_ready` pulses with `*_data` = `mem_rdata` registered and `*_err` = 0;
  - for stores, `data_rd` = 0.
- INST/DATA → IDLE when `wait_cnt` reaches `TIMEOUT-1` without `mem_ack`:
  - `mem_req` drops;
  - the owner's `*_ready` and `*_err` pulse; data = 0.
  - A late `mem_ack` arriving in IDLE is ignored.
- Byte enables and write data by size:
  - byte: `mem_be` = 0001 << `addr[1:0]`; `mem_wdata` = {4{`data_wr[7:0]`}}.
  - half: `mem_be` = 0011 << `addr[1:0]`; `mem_wdata` = {2{`data_wr[15:0]`}}.
  - word: `mem_be` = 1111; `mem_wdata` = `data_wr`.
  - Instruction reads: `mem_be` = 1111, `mem_we` = 0.
- `mem_ack` and `mem_rdata` are sampled only in INST/DATA; an ack in the same cycle as the timeout takes precedence (normal completion).

## Timing
- Reset values:
  - state = IDLE; `wait_cnt` = `burst_cnt` = 0;
  - all outputs 0: `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, `*_ready`, `*_err`, `*_data`.
- Reset mid-access: `mem_req` is 0 after the reset edge and no `*_ready` is produced for the aborted access.
- Latency, request seen in cycle 0:
  - `mem_req` high in cycle 1;
  - with `mem_ack` in cycle k ≥ 1, `*_ready` is in cycle k+1.
  - The next arbitration is in cycle k+1; the next `mem_req` is no earlier than cycle k+2.
- Zero-wait memory gives 2-cycle latency and one access per 2 cycles.
- `*_ready` and `*_err` are exactly one cycle wide, qualified by `clk_en`.

## Structure
- Shared package additions:
  - `memArbState_e` (IDLE/INST/DATA);
  - `memOwner_e` (OWN_INST/OWN_DATA);
  - size constants reusing the existing `funct3ITypeLOAD_e` size encoding;
  - `MEM_BE_W` = 4.
- Counter widths: `$clog2(TIMEOUT+1)` and `$clog2(DATA_BURST+1)`, both unsigned.
- Sub-module `mem_lane_align`: combinational size/address → `mem_be`, `mem_wdata`, `misaligned`.

## Test plan
- Instruction read at 0x0000_0100, `mem_ack` in the cycle after `mem_req` → `mem_addr` = 0x100, `mem_be` = 1111, `inst_ready` in cycle 3 with `inst_data` = `mem_rdata` (0x0000_0013), `inst_err` = 0.
- Store byte 0xA5 to 0x0000_0203 → `mem_we` = 1, `mem_addr` = 0x200, `mem_be` = 1000, `mem_wdata` = 0xA5A5_A5A5, `data_ready` 1 cycle after ack.
- Simultaneous inst and data requests, both held, `DATA_BURST` = 4 → grant order D, D, D, D, I; `burst_cnt` returns to 0.
- Word load at 0x0000_0102 → no `mem_req`, `data_ready` = `data_err` = 1 next cycle, `data_rd` = 0.
- `TIMEOUT` = 8, no ack → `mem_req` drops 8 cycles after rising, `inst_ready` = `inst_err` = 1; a late ack 2 cycles later produces no pulse.
- Assert `rst` while in DATA with `mem_req` = 1 → next cycle all outputs 0, state IDLE, no `data_ready`; `clk_en` low for 5 cycles mid-wait → `wait_cnt` and outputs frozen.
